// File: rtl/rpl_checker.sv
// Receive-side checker for the registered delay line: shadow pipeline, mismatch counter, fail flag.
// Define RPL_CHK_CAPTURE_EN to build the first-mismatch capture registers.
module rpl_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned RST_VAL   = 10,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     d_src,
  input  logic [WIDTH-1:0]     d_obs,
  output logic                 checking,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 fail,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_obs
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0]      FillLast = CntW'(LATENCY - 1);
  localparam logic [WIDTH-1:0]     RstVal   = WIDTH'(RST_VAL);
  localparam logic [ERR_CNT_W-1:0] ErrLimit = ERR_CNT_W'(ERR_LIMIT);
  localparam logic [ERR_CNT_W-1:0] ErrMax   = '1;

  typedef enum logic [1:0] {StIdle, StFill, StCheck, StFail} state_e;

  state_e               state;
  logic [CntW-1:0]      fill_cnt;
  logic [WIDTH-1:0]     exp_pipe [LATENCY];
  logic                 miss;
  logic [ERR_CNT_W-1:0] err_inc;

  // Shadow of the delay line; shares its reset value so both stay aligned after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < LATENCY; k++) exp_pipe[k] <= RstVal;
    end else begin
      exp_pipe[0] <= d_src;
      for (int unsigned k = 1; k < LATENCY; k++) exp_pipe[k] <= exp_pipe[k-1];
    end
  end

  assign miss    = (d_obs != exp_pipe[LATENCY-1]);
  assign err_inc = (err_cnt == ErrMax) ? err_cnt : err_cnt + ERR_CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      fill_cnt <= '0;
      checking <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      fail     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (clear) begin
        state    <= StIdle;
        fill_cnt <= '0;
        checking <= 1'b0;
        err_cnt  <= '0;
        fail     <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (enable) begin
              state    <= StFill;
              fill_cnt <= '0;
            end
          end
          StFill: begin
            fill_cnt <= fill_cnt + CntW'(1);
            if (!enable) begin
              state <= StIdle;
            end else if (fill_cnt == FillLast) begin
              state    <= StCheck;
              checking <= 1'b1;
            end
          end
          StCheck: begin
            // The compare of the cycle in which enable drops still counts.
            if (miss) begin
              mismatch <= 1'b1;
              err_cnt  <= err_inc;
            end
            if (miss && (err_inc == ErrLimit)) begin
              state    <= StFail;
              fail     <= 1'b1;
              checking <= 1'b0;
            end else if (!enable) begin
              state    <= StIdle;
              checking <= 1'b0;
            end
          end
          StFail: begin
            fail <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef RPL_CHK_CAPTURE_EN
  // err_cnt is zero exactly until the first counted mismatch since reset or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_exp <= '0;
      first_obs <= '0;
    end else if (clear) begin
      first_exp <= '0;
      first_obs <= '0;
    end else if ((state == StCheck) && miss && (err_cnt == '0)) begin
      first_exp <= exp_pipe[LATENCY-1];
      first_obs <= d_obs;
    end
  end
`else
  assign first_exp = '0;
  assign first_obs = '0;
`endif

endmodule
